// File: rtl/tt_matmul_host_sequencer.sv
// Host-side sequencer for the matrix multiplier tile: streams A/B operands onto
// the tile input buses, then captures the returned 16-bit C elements.
module tt_matmul_host_sequencer #(
  parameter int N          = 2,
  parameter int DW         = 8,
  parameter int RESULT_LAT = 2,
  localparam int E         = N * N,
  localparam int IW        = (E > 1) ? $clog2(E) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [IW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] mat_a_out,
  output logic [DW-1:0] mat_b_out,
  input  logic [7:0]    mat_c_lo_in,
  input  logic [7:0]    mat_c_hi_in,
  input  logic [IW-1:0] rd_addr,
  output logic [15:0]   rd_data
);

  // The counter also times the WAIT phase, so it must hold RESULT_LAT-1 (up to 14).
  localparam int IW1 = IW + 1;
  localparam int CW  = (IW1 > 4) ? IW1 : 4;
  localparam logic [CW-1:0]  E_LAST   = CW'(E - 1);
  localparam logic [CW-1:0]  LAT_LAST = (RESULT_LAT > 0) ? CW'(RESULT_LAT - 1) : CW'(0);
  localparam logic [IW1-1:0] E_LIM    = IW1'(E);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [DW-1:0] a_mem [E];
  logic [DW-1:0] b_mem [E];
  logic [15:0]   c_mem [E];
  logic          wr_ok;
  logic          rd_ok;

  assign wr_ok = ({1'b0, wr_addr} < E_LIM);
  assign rd_ok = ({1'b0, rd_addr} < E_LIM);

  // Next-state and phase counter; each phase ends when the count reaches its last index.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (start && !wr_en) begin
          state_nxt = S_LOAD;
          cnt_nxt   = '0;
        end else begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      end
      S_LOAD: begin
        if (cnt == E_LAST) begin
          state_nxt = (RESULT_LAT == 0) ? S_CAPTURE : S_WAIT;
          cnt_nxt   = '0;
        end else begin
          state_nxt = S_LOAD;
          cnt_nxt   = cnt + CW'(1);
        end
      end
      S_WAIT: begin
        if (cnt == LAT_LAST) begin
          state_nxt = S_CAPTURE;
          cnt_nxt   = '0;
        end else begin
          state_nxt = S_WAIT;
          cnt_nxt   = cnt + CW'(1);
        end
      end
      S_CAPTURE: begin
        if (cnt == E_LAST) begin
          state_nxt = S_DONE;
          cnt_nxt   = '0;
        end else begin
          state_nxt = S_CAPTURE;
          cnt_nxt   = cnt + CW'(1);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State register; outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mat_a_out <= '0;
      mat_b_out <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      busy      <= (state_nxt == S_LOAD) || (state_nxt == S_WAIT) || (state_nxt == S_CAPTURE);
      done      <= (state_nxt == S_DONE);
      mat_a_out <= (state_nxt == S_LOAD) ? a_mem[cnt_nxt[IW-1:0]] : '0;
      mat_b_out <= (state_nxt == S_LOAD) ? b_mem[cnt_nxt[IW-1:0]] : '0;
    end
  end

  // Operand and result storage; operands change only in IDLE, results only in CAPTURE.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < E; i++) begin
        a_mem[i] <= '0;
        b_mem[i] <= '0;
        c_mem[i] <= '0;
      end
    end else begin
      if ((state == S_IDLE) && wr_en && wr_ok) begin
        if (wr_sel) begin
          b_mem[wr_addr] <= wr_data;
        end else begin
          a_mem[wr_addr] <= wr_data;
        end
      end
      if (state == S_CAPTURE) begin
        c_mem[cnt[IW-1:0]] <= {mat_c_hi_in, mat_c_lo_in};
      end
    end
  end

  // Combinational result read; indices past the matrix read as zero.
  always_comb begin
    if (rd_ok) begin
      rd_data = c_mem[rd_addr];
    end else begin
      rd_data = 16'h0000;
    end
  end

endmodule
